// File: rtl/md5_pkg.sv
// -----------------------------------------------------------------------------
// md5_pkg
// Shared definitions for the MD5 front end (md5_part_feeder, md5_part_buffer).
//   PART_W / PART_BYTES : size of one MD5 message part (512 bits / 64 bytes)
//   HASH_W              : width of the MD5 digest
//   LEN_OUT_W           : width of the total-length bus to the core (bits)
//   state_t             : feeder FSM states
//   bitrev8()           : byte placement helper (message bit order is
//                         MSB-first, part bit order is LSB-first)
// -----------------------------------------------------------------------------
package md5_pkg;

    localparam int PART_W     = 512;
    localparam int PART_BYTES = 64;
    localparam int HASH_W     = 128;
    localparam int LEN_OUT_W  = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        SEND      = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_RDY  = 3'd4,
        WAIT_HASH = 3'd5,
        DONE      = 3'd6
    } state_t;

    // Byte bit b lands at part bit 8*k + (7-b): reverse the byte.
    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[7-i] = b[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/md5_part_buffer.sv
// -----------------------------------------------------------------------------
// md5_part_buffer
// 512-bit part register with per-byte write enables. Each enabled byte j of
// the beat is bit-reversed and stored at byte slot ptr_i + j.
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset (clears buffer)
//   clr_i          : synchronous clear of the whole part
//   wr_i           : write the beat this cycle
//   ptr_i          : byte slot of beat byte 0 (multiple of IN_BYTES)
//   data_i         : beat data, byte 0 in data_i[7:0]
//   mask_i         : per-byte enable (bytes past the message end are 0)
//   part_o         : registered part contents
// -----------------------------------------------------------------------------
module md5_part_buffer
    import md5_pkg::*;
#(
    parameter int IN_BYTES = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clr_i,
    input  logic                  wr_i,
    input  logic [5:0]            ptr_i,
    input  logic [IN_BYTES*8-1:0] data_i,
    input  logic [IN_BYTES-1:0]   mask_i,
    output logic [PART_W-1:0]     part_o
);

    logic [PART_W-1:0] part_q, part_d;

    always_comb begin
        part_d = part_q;
        if (clr_i) begin
            part_d = '0;
        end else if (wr_i) begin
            for (int j = 0; j < IN_BYTES; j++) begin
                if (mask_i[j]) begin
                    part_d[{ptr_i + 6'(j), 3'b000} +: 8] = bitrev8(data_i[8*j +: 8]);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            part_q <= '0;
        end else begin
            part_q <= part_d;
        end
    end

    assign part_o = part_q;

endmodule

// File: rtl/md5_part_feeder.sv
// -----------------------------------------------------------------------------
// md5_part_feeder
// Byte-stream front end for the MD5 core: packs a length-announced message
// into 512-bit parts, hands them to the core and latches the final hash.
// Optional watchdog: define MD5_PART_FEEDER_TIMEOUT_EN.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   start / start_ready        : request a new message (taken in IDLE/DONE)
//   msg_len_bytes              : message length, sampled with start
//   in_data/in_valid/in_ready  : byte beats, byte 0 = in_data[7:0]
//   part_out/part_out_ready    : part to the core
//   total_data_length          : message length in bits to the core
//   core_ready_for_next_part   : core part handshake
//   core_hash/core_hash_valid  : digest from the core
//   hash_out/hash_out_valid    : latched digest, valid in DONE
//   error                      : watchdog expiry (0 without the watchdog)
//   dbg_state                  : current FSM state
// Handshakes: a beat transfers on a posedge where in_valid && in_ready; a
// start is taken on a posedge where start && start_ready. Toward the core,
// part_out_ready rises once core_ready_for_next_part is seen high and falls
// after the core drops it; part_out does not change while part_out_ready=1.
// -----------------------------------------------------------------------------
module md5_part_feeder
    import md5_pkg::*;
#(
    parameter int IN_BYTES = 4,
    parameter int LEN_W    = 61
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  start_ready,
    input  logic [LEN_W-1:0]      msg_len_bytes,
    input  logic [IN_BYTES*8-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [PART_W-1:0]     part_out,
    output logic                  part_out_ready,
    output logic [LEN_OUT_W-1:0]  total_data_length,
    input  logic                  core_ready_for_next_part,
    input  logic [HASH_W-1:0]     core_hash,
    input  logic                  core_hash_valid,
    output logic [HASH_W-1:0]     hash_out,
    output logic                  hash_out_valid,
    output logic                  error,
    output state_t                dbg_state
);

    localparam int NP_W  = LEN_W - 5;   // holds ceil(len/64) without overflow
    localparam int PC_W  = LEN_W - 6;
    localparam int PTR_W = 7;           // 0..64

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [NP_W-1:0]   n_parts_q, n_parts_d;
    logic [PC_W-1:0]   part_cnt_q, part_cnt_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [HASH_W-1:0] hash_q, hash_d;
    logic              start_ready_q, start_ready_d;
    logic              in_ready_q, in_ready_d;
    logic              por_q, por_d;
    logic              hval_q, hval_d;

    logic [LEN_W-1:0]    remaining;
    logic [LEN_W-1:0]    take;
    logic [IN_BYTES-1:0] mask;
    logic                buf_clr, buf_wr;
    logic                start_acc;

`ifdef MD5_PART_FEEDER_TIMEOUT_EN
    localparam logic [23:0] TIMEOUT_CYCLES = 24'((1 << 20) - 1);
    logic [23:0] wdog_q, wdog_d;
    logic        error_q, error_d;
    logic        waiting;
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        n_parts_d  = n_parts_q;
        part_cnt_d = part_cnt_q;
        ptr_d      = ptr_q;
        hash_d     = hash_q;
        buf_clr    = 1'b0;
        buf_wr     = 1'b0;
        start_acc  = 1'b0;

        // Bytes of the current beat that still belong to the message.
        remaining = len_q - byte_cnt_q;
        take      = (remaining >= LEN_W'(IN_BYTES)) ? LEN_W'(IN_BYTES) : remaining;
        for (int j = 0; j < IN_BYTES; j++) begin
            mask[j] = (remaining > LEN_W'(j));
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    len_d      = msg_len_bytes;
                    byte_cnt_d = '0;
                    part_cnt_d = '0;
                    ptr_d      = '0;
                    buf_clr    = 1'b1;
                    if (msg_len_bytes == '0) begin
                        n_parts_d = NP_W'(1);
                        state_d   = SEND;
                    end else begin
                        n_parts_d = NP_W'(msg_len_bytes[LEN_W-1:6])
                                  + NP_W'(|msg_len_bytes[5:0]);
                        state_d   = FILL;
                    end
                end
            end
            FILL: begin
                if (in_ready_q && in_valid) begin
                    buf_wr     = 1'b1;
                    byte_cnt_d = byte_cnt_q + take;
                    ptr_d      = ptr_q + PTR_W'(IN_BYTES);
                    if (ptr_d == PTR_W'(PART_BYTES) || byte_cnt_d == len_q) begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (core_ready_for_next_part) state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!core_ready_for_next_part) begin
                    part_cnt_d = part_cnt_q + PC_W'(1);
                    state_d    = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if ({1'b0, part_cnt_q} < n_parts_q) begin
                    if (core_ready_for_next_part) begin
                        buf_clr = 1'b1;
                        ptr_d   = '0;
                        state_d = FILL;
                    end
                end else begin
                    state_d = WAIT_HASH;
                end
            end
            WAIT_HASH: begin
                if (core_hash_valid) begin
                    hash_d  = core_hash;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef MD5_PART_FEEDER_TIMEOUT_EN
        error_d = start_acc ? 1'b0 : error_q;
        waiting = (state_q == SEND) || (state_q == WAIT_ACK) ||
                  (state_q == WAIT_RDY) || (state_q == WAIT_HASH);
        if (waiting && wdog_q == TIMEOUT_CYCLES) begin
            error_d = 1'b1;
            state_d = IDLE;
        end
        wdog_d = (!waiting || state_d != state_q) ? 24'd0 : wdog_q + 24'd1;
`endif

        // Outputs are registered copies decoded from the next state.
        start_ready_d = (state_d == IDLE) || (state_d == DONE);
        in_ready_d    = (state_d == FILL);
        por_d         = (state_d == WAIT_ACK);
        hval_d        = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            len_q         <= '0;
            byte_cnt_q    <= '0;
            n_parts_q     <= '0;
            part_cnt_q    <= '0;
            ptr_q         <= '0;
            hash_q        <= '0;
            start_ready_q <= 1'b1;
            in_ready_q    <= 1'b0;
            por_q         <= 1'b0;
            hval_q        <= 1'b0;
`ifdef MD5_PART_FEEDER_TIMEOUT_EN
            wdog_q        <= '0;
            error_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            byte_cnt_q    <= byte_cnt_d;
            n_parts_q     <= n_parts_d;
            part_cnt_q    <= part_cnt_d;
            ptr_q         <= ptr_d;
            hash_q        <= hash_d;
            start_ready_q <= start_ready_d;
            in_ready_q    <= in_ready_d;
            por_q         <= por_d;
            hval_q        <= hval_d;
`ifdef MD5_PART_FEEDER_TIMEOUT_EN
            wdog_q        <= wdog_d;
            error_q       <= error_d;
`endif
        end
    end

    md5_part_buffer #(.IN_BYTES(IN_BYTES)) u_buf (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (buf_clr),
        .wr_i    (buf_wr),
        .ptr_i   (ptr_q[5:0]),
        .data_i  (in_data),
        .mask_i  (mask),
        .part_o  (part_out)
    );

    assign start_ready       = start_ready_q;
    assign in_ready          = in_ready_q;
    assign part_out_ready    = por_q;
    assign hash_out          = hash_q;
    assign hash_out_valid    = hval_q;
    assign total_data_length = LEN_OUT_W'({len_q, 3'b000});
    assign dbg_state         = state_q;
`ifdef MD5_PART_FEEDER_TIMEOUT_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_md5_part_feeder.sv
module tb_md5_part_feeder;
    import md5_pkg::*;

    localparam int IB = 4;
    localparam int LW = 61;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            start_ready;
    logic [LW-1:0]   msg_len_bytes;
    logic [IB*8-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [511:0]    part_out;
    logic            part_out_ready;
    logic [63:0]     total_data_length;
    logic            core_rdy;
    logic [127:0]    core_hash;
    logic            core_hash_valid;
    logic [127:0]    hash_out;
    logic            hash_out_valid;
    logic            error;
    state_t          dbg_state;

    md5_part_feeder #(.IN_BYTES(IB), .LEN_W(LW)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .start                    (start),
        .start_ready              (start_ready),
        .msg_len_bytes            (msg_len_bytes),
        .in_data                  (in_data),
        .in_valid                 (in_valid),
        .in_ready                 (in_ready),
        .part_out                 (part_out),
        .part_out_ready           (part_out_ready),
        .total_data_length        (total_data_length),
        .core_ready_for_next_part (core_rdy),
        .core_hash                (core_hash),
        .core_hash_valid          (core_hash_valid),
        .hash_out                 (hash_out),
        .hash_out_valid           (hash_out_valid),
        .error                    (error),
        .dbg_state                (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard state ----------------
    int           checks = 0;
    int           errors = 0;
    logic [7:0]   msg[$];        // message bytes plus tail garbage of last beat
    int           cur_len;
    logic [511:0] last_part;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: message bit m (MSB-first from byte 0) goes to part m/512, bit m%512.
    function automatic logic [511:0] model_part(input int p);
        logic [511:0] r;
        int m;
        r = '0;
        for (int i = 0; i < 512; i++) begin
            m = p * 512 + i;
            if (m < cur_len * 8) r[i] = msg[m / 8][7 - (m % 8)];
        end
        return r;
    endfunction

    function automatic int nparts(input int len);
        return (len == 0) ? 1 : (len + 63) / 64;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0; msg_len_bytes = '0; in_data = '0; in_valid = 1'b0;
        core_rdy = 1'b0; core_hash = '0; core_hash_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_start_ready", start_ready, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_part_out_ready", part_out_ready, 0);
        chk("rst_part_out", part_out, 0);
        chk("rst_hash_valid", hash_out_valid, 0);
        chk("rst_hash_out", hash_out, 0);
        chk("rst_total_len", total_data_length, 0);
        chk("rst_error", error, 0);
        chk("rst_state", dbg_state, IDLE);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic start_msg(input int len, input bit abc);
        int nb;
        nb = (len + IB - 1) / IB;
        msg.delete();
        for (int i = 0; i < nb * IB; i++) msg.push_back(8'($urandom));
        if (abc) begin
            msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63; msg[3] = 8'h00;
        end
        cur_len = len;
        @(posedge clk); #1;
        start = 1'b1;
        msg_len_bytes = LW'(len);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("total_len", total_data_length, 64'(len) * 64'd8);
        chk("busy_after_start", start_ready, 0);
    endtask

    task automatic drive_beats(input int first, input int nbeats, input bit rnd);
        int idx, guard;
        idx = 0; guard = 0;
        while (idx < nbeats && guard < 5000) begin
            @(posedge clk); #1;
            if (rnd && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                for (int j = 0; j < IB; j++) in_data[8*j +: 8] = msg[(first + idx) * IB + j];
            end
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("beats_consumed", idx, nbeats);
    endtask

    task automatic wait_por(input logic lvl);
        int g;
        g = 0;
        @(negedge clk);
        while (part_out_ready !== lvl && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk("part_out_ready_wait", part_out_ready, lvl);
    endtask

    task automatic core_stub(input int np, input int stall, input logic [127:0] h);
        logic [511:0] snap;
        for (int p = 0; p < np; p++) begin
            @(posedge clk); #1;
            core_rdy = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("no_early_part", part_out_ready, 0);
            end
            @(posedge clk); #1;
            core_rdy = 1'b1;
            wait_por(1'b1);
            snap = part_out;
            last_part = snap;
            chk($sformatf("part%0d", p), snap, model_part(p));
            for (int s = 0; s < 3; s++) begin
                @(negedge clk);
                chk("part_stable", part_out, snap);
            end
            @(posedge clk); #1;
            core_rdy = 1'b0;
            wait_por(1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        core_hash = h;
        core_hash_valid = 1'b1;
        @(posedge clk); #1;
        core_hash_valid = 1'b0;
        @(negedge clk);
        chk("hash_valid", hash_out_valid, 1);
        chk("hash_out", hash_out, h);
    endtask

    task automatic run_msg(input int len, input bit abc, input int stall, input bit rnd,
                           input logic [127:0] h);
        start_msg(len, abc);
        fork
            drive_beats(0, (len + IB - 1) / IB, rnd);
            core_stub(nparts(len), stall, h);
        join
        @(negedge clk);
        chk("done_state", dbg_state, DONE);
        chk("done_start_ready", start_ready, 1);
        chk("done_error", error, 0);
        // beats offered outside FILL are not taken
        @(posedge clk); #1;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("in_ready_outside_fill", in_ready, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [127:0] rand_hash();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        do_reset();

        // empty message: one all-zero part
        run_msg(0, 1'b0, 2, 1'b0, 128'hd41d8cd98f00b204e9800998ecf8427e);
        chk("len0_part_zero", last_part, '0);

        // "abc" in one beat, fourth byte dropped
        run_msg(3, 1'b1, 2, 1'b0, rand_hash());
        chk("abc_part", last_part, 512'hC64686);

        // part boundary
        run_msg(64, 1'b0, 2, 1'b0, rand_hash());
        run_msg(65, 1'b0, 2, 1'b0, rand_hash());
        chk("len65_tail_zero", last_part >> 8, '0);

        // stalling core and bursty source
        run_msg(150, 1'b0, 50, 1'b1, rand_hash());

        // reset during WAIT_ACK of part 2 of 3
        start_msg(130, 1'b0);
        @(posedge clk); #1;
        core_rdy = 1'b1;
        drive_beats(0, 16, 1'b0);
        wait_por(1'b1);
        chk("rst_run_part0", part_out, model_part(0));
        @(posedge clk); #1;
        core_rdy = 1'b0;
        wait_por(1'b0);
        @(posedge clk); #1;
        core_rdy = 1'b1;
        drive_beats(16, 16, 1'b0);
        wait_por(1'b1);
        chk("rst_run_part1", part_out, model_part(1));
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk("async_rst_por", part_out_ready, 0);
        chk("async_rst_start_ready", start_ready, 1);
        chk("async_rst_state", dbg_state, IDLE);
        @(posedge clk); #1;
        reset = 1'b0;
        core_rdy = 1'b0;
        run_msg(5, 1'b0, 3, 1'b1, rand_hash());

        // random lengths
        for (int k = 0; k < 3; k++) begin
            run_msg($urandom_range(1, 300), 1'b0, $urandom_range(0, 6), 1'b1, rand_hash());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/md5_part_feeder.md
Name: md5_part_feeder

Overview:
- Front end of the MD5 core: accepts a message as a byte stream with a length announced up front.
- Packs bytes into 512-bit parts, drives the core's part handshake and total-length input, then captures the returned hash.
- Sits between any byte source (UART, DMA, bus slave) and the md5 core; performs the same job the bench does, in synthesizable form.

Parameters:
- IN_BYTES, 4, bytes per input beat; legal values are 1, 2, 4, 8.
- LEN_W, 61, width of the byte-length input; total_data_length = {msg_len_bytes, 3'b000}, truncated to 64 bits.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  start request, accepted only when start_ready=1.
- start_ready  out  1  high in IDLE and DONE.
- msg_len_bytes  in  LEN_W  message length in bytes, sampled with start.
- in_data  in  IN_BYTES*8  beat data; byte 0 = in_data[7:0] is earliest.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid&&in_ready at posedge.
- part_out  out  512  to core part_in.
- part_out_ready  out  1  to core part_in_ready.
- total_data_length  out  64  to core; held stable from start to DONE.
- core_ready_for_next_part  in  1  from core ready_for_next_part.
- core_hash  in  128  from core hash.
- core_hash_valid  in  1  from core hash_valid.
- hash_out  out  128  latched hash.
- hash_out_valid  out  1  high in DONE.
- error  out  1  sticky until next accepted start; only driven when the optional feature is enabled, else tied 0.

Behaviour:
- Reset values: all outputs 0, state IDLE, except start_ready=1. Reset mid-operation aborts immediately; part_out_ready drops asynchronously. No partial part is resumed.
- Part count N = max(1, ceil(len/64)). A zero-length message still sends one all-zero part.
- Bit mapping: message bit i, counted MSB-first from byte 0, goes to part_out[i % 512]. Byte k, bit b therefore lands at part_out[8*(k%64) + (7-b)]. Unused bytes of the final part are 0.
- Input packing: each accepted beat writes up to IN_BYTES bytes at the byte pointer. Bytes beyond len in the final beat are discarded. A beat never straddles parts, because IN_BYTES divides 64.
- State IDLE/DONE: on start, latch len, clear the part buffer, pointer, counters and hash_out_valid, then go to FILL. For len==0, go directly to SEND.
- State FILL: in_ready=1. When the pointer reaches 64 bytes or the byte count reaches len, go to SEND on the next cycle. in_ready is 0 in that cycle.
- State SEND: wait for core_ready_for_next_part=1, then assert part_out_ready and go to WAIT_ACK. part_out is frozen while part_out_ready=1.
- State WAIT_ACK: hold part_out_ready=1 until core_ready_for_next_part=0. Then deassert, increment the part counter, and go to WAIT_RDY.
- State WAIT_RDY:
  - If parts sent < N: wait for core_ready_for_next_part=1, clear the buffer, go to FILL.
  - Else go to WAIT_HASH.
  - core_hash_valid is ignored before the last part.
- State WAIT_HASH: on core_hash_valid=1, latch core_hash into hash_out and go to DONE. Latency is 1 cycle from core_hash_valid to hash_out_valid.
- State DONE: hash_out_valid=1 and start_ready=1. If start and core_hash_valid coincide in DONE, start wins.
- start asserted outside IDLE/DONE is ignored.
- in_valid outside FILL is ignored; no beat is consumed.
- Counters: byte count is LEN_W bits and part count is LEN_W-6 bits. No wrap is possible within a legal len.

Optional Feature:
- Macro MD5_PART_FEEDER_TIMEOUT_EN.
- With it: a 24-bit watchdog runs in SEND, WAIT_ACK, WAIT_RDY and WAIT_HASH, and reloads on every state change. On reaching TIMEOUT_CYCLES (localparam 2^20-1), the block sets error=1, drops part_out_ready, and returns to IDLE.
- Without it: waits are unbounded and error is constant 0.

Decomposition:
- Package md5_pkg holds:
  - PART_W=512, PART_BYTES=64, HASH_W=128, LEN_OUT_W=64.
  - The state enum {IDLE, FILL, SEND, WAIT_ACK, WAIT_RDY, WAIT_HASH, DONE}.
  - A function for the byte-to-bit-reversed placement.
- One sub-module, md5_part_buffer: the 512-bit register with byte-write enables and the bit-reversal, written from the beat and the pointer. The FSM, counters and handshake stay in md5_part_feeder.

Test Plan:
- len=0, start → one part; part_out=0, total_data_length=0. Stub core returns d41d8cd98f00b204e9800998ecf8427e → hash_out equals it, hash_out_valid=1.
- "abc" (len=3, IN_BYTES=4, beat 0x00636261) → part_out[7:0]=8'h86, [15:8]=8'h46, [23:16]=8'hC6, rest 0; total_data_length=24. The 4th byte is dropped and exactly 1 beat is consumed.
- len=64 → exactly 1 part. len=65 → 2 parts; the second has only byte 64 placed at part_out[7:0], rest 0; total_data_length=520.
- Core stalls: core_ready_for_next_part held low 50 cycles, and in_valid toggled randomly → no part_out_ready before ready=1; part_out is stable during WAIT_ACK; no beat is lost or duplicated.
- reset pulsed during WAIT_ACK of part 2 of 3 → part_out_ready=0 in the same cycle and start_ready=1. A new start with len=5 completes correctly.
- With MD5_PART_FEEDER_TIMEOUT_EN and the core never ready → error=1 after 2^20-1 cycles in SEND, state IDLE. The next start clears error.
